// File: rtl/com_uart.sv
// com_uart: 8N1 UART with independent transmitter and receiver.
//
// Parameters
//   CLK_FREQ     input clock frequency in Hz
//   BAUD         serial bit rate; one bit lasts DIV = CLK_FREQ/BAUD cycles (DIV >= 4)
//
// Ports
//   clk50M       system clock, all logic on rising edge
//   rst          asynchronous active-high reset
//   data_in      byte to transmit, sampled with enable_write
//   enable_write one-cycle transmit request, honoured only while write_ready=1
//   write_ready  1 = transmitter idle
//   data_out     last received byte
//   read_ready   1 = unread byte in data_out
//   int_ack      read acknowledge, clears read_ready (level-sensitive)
//   rxd          serial input, asynchronous, idle high
//   txd          serial output, idle high
//   frame_err    one-cycle pulse when a stop bit is sampled low
//   overrun      one-cycle pulse when a byte lands while read_ready=1
module com_uart #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       enable_write,
  output logic       write_ready,
  output logic [7:0] data_out,
  output logic       read_ready,
  input  logic       int_ack,
  input  logic       rxd,
  output logic       txd,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            txd_q, txd_d;

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (enable_write) begin
          tx_byte_d  = data_in;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // txd is registered from the next state so the line is glitch-free and
    // still reacts on the cycle after acceptance.
    unique case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_byte_d[tx_bit_d];
      default:  txd_d = 1'b1;
    endcase
  end

  assign write_ready = (tx_state_q == TX_IDLE);
  assign txd         = txd_q;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Synchronizer and edge-history flops reset low: a start is only recognised
  // after the line has been seen high, so a line held low through reset (or
  // after a framing error) never triggers a frame.
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            read_ready_q, read_ready_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      rx_s1_q      <= 1'b0;
      rx_s2_q      <= 1'b0;
      rx_prev_q    <= 1'b0;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      data_out_q   <= '0;
      read_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_s1_q      <= rxd;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      data_out_q   <= data_out_d;
      read_ready_q <= read_ready_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    data_out_d   = data_out_q;
    read_ready_d = int_ack ? 1'b0 : read_ready_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_MID) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          // High at the start mid-point is a glitch, not a start bit.
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_s2_q) begin
            // A landing byte wins over a coincident ack; only an
            // unacknowledged previous byte counts as overrun.
            data_out_d   = rx_shift_q;
            read_ready_d = 1'b1;
            overrun_d    = read_ready_q && !int_ack;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign data_out   = data_out_q;
  assign read_ready = read_ready_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_com_uart.sv
// Directed bench for com_uart at CLK_FREQ=160, BAUD=10 (DIV=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_com_uart;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int DIV      = 16;
  // Receive landing: rxd low before posedge k=1, byte visible after posedge
  // 9.5*DIV+2 = 154 later, i.e. at falling edge k=155.
  localparam int LAND_K   = 155;

  logic       clk50M = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       enable_write;
  logic       write_ready;
  logic [7:0] data_out;
  logic       read_ready;
  logic       int_ack;
  logic       rxd;
  logic       txd;
  logic       frame_err;
  logic       overrun;

  always #5 clk50M = ~clk50M;

  com_uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk50M      (clk50M),
    .rst         (rst),
    .data_in     (data_in),
    .enable_write(enable_write),
    .write_ready (write_ready),
    .data_out    (data_out),
    .read_ready  (read_ready),
    .int_ack     (int_ack),
    .rxd         (rxd),
    .txd         (txd),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  // Pulses are read before the edge updates them, so each cycle a pulse is
  // high is counted exactly once.
  always @(posedge clk50M) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1)   ov_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk50M);
  endtask

  // Drives one 10-bit frame onto rxd, one bit per DIV cycles. k counts rising
  // edges since the start bit was applied. ack_k >= 0 pulses int_ack so it is
  // seen on rising edge ack_k+1. lat enables the landing-latency checks.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_k,
                            input bit lat);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int k = 0; k < 10 * DIV; k++) begin
      rxd = fr[k / DIV];
      if (lat && k == LAND_K - 1) chk("rx_not_yet_ready", 32'(read_ready), 32'd0);
      if (lat && k == LAND_K) begin
        chk("rx_ready_on_land", 32'(read_ready), 32'd1);
        chk("rx_data_on_land", 32'(data_out), 32'(b));
        int_ack = 1'b1;
      end
      if (lat && k == LAND_K + 1) begin
        chk("ack_clears_next", 32'(read_ready), 32'd0);
        int_ack = 1'b0;
      end
      if (ack_k >= 0 && k == ack_k)     int_ack = 1'b1;
      if (ack_k >= 0 && k == ack_k + 1) int_ack = 1'b0;
      @(negedge clk50M);
    end
    rxd = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;      // bit-time order: [0]=start ... [9]=stop
    logic       poke;       // issue a second write while busy
    logic [7:0] poke_data;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pre_ack;
    logic       exp_rr;
    logic [7:0] exp_dout;
    int         exp_fe;
    int         exp_ov;
  } rx_vec_t;

  tx_vec_t txv[4];
  rx_vec_t rxv[4];

  initial begin
    int fe0, ov0;

    txv[0] = '{8'hA5, 10'b1_10100101_0, 1'b0, 8'h00};
    txv[1] = '{8'h00, 10'b1_00000000_0, 1'b0, 8'h00};
    txv[2] = '{8'h3C, 10'b1_00111100_0, 1'b0, 8'h00};
    txv[3] = '{8'h0F, 10'b1_00001111_0, 1'b1, 8'hFF};

    rxv[0] = '{8'h11, 1'b1, 1'b1, 1'b1, 8'h11, 0, 0};
    rxv[1] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 0, 1};
    rxv[2] = '{8'h55, 1'b0, 1'b1, 1'b0, 8'h22, 1, 0};
    rxv[3] = '{8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 0, 0};

    rst = 1'b1; rxd = 1'b1; data_in = 8'h00; enable_write = 1'b0; int_ack = 1'b0;
    cyc(3);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_write_ready", 32'(write_ready), 32'd1);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_read_ready", 32'(read_ready), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    cyc(5);

    // Transmit table; vectors follow back-to-back on the ready cycle.
    for (int i = 0; i < 4; i++) begin
      data_in = txv[i].data;
      enable_write = 1'b1;
      @(negedge clk50M);
      enable_write = 1'b0;
      data_in = ~txv[i].data;
      for (int c = 0; c <= 10 * DIV; c++) begin
        if (c % DIV == DIV / 2) begin
          chk($sformatf("tx%0d_bit%0d", i, c / DIV), 32'(txd), 32'(txv[i].frame[c / DIV]));
          chk($sformatf("tx%0d_busy%0d", i, c / DIV), 32'(write_ready), 32'd0);
        end
        if (c == 10 * DIV - 1) chk($sformatf("tx%0d_ready_early", i), 32'(write_ready), 32'd0);
        if (c == 10 * DIV) begin
          chk($sformatf("tx%0d_ready_back", i), 32'(write_ready), 32'd1);
          chk($sformatf("tx%0d_idle_line", i), 32'(txd), 32'd1);
        end
        if (txv[i].poke && c == 3 * DIV) begin
          data_in = txv[i].poke_data;
          enable_write = 1'b1;
        end
        if (txv[i].poke && c == 3 * DIV + 1) enable_write = 1'b0;
        if (c < 10 * DIV) @(negedge clk50M);
      end
    end
    cyc(DIV);
    chk("tx_no_extra_frame", 32'(write_ready), 32'd1);

    // Receive landing latency and ack clearing.
    cyc(2 * DIV);
    send_frame(8'h3C, 1'b1, -1, 1'b1);
    cyc(4);

    // 4-cycle low glitch must leave everything alone.
    fe0 = fe_cnt; ov0 = ov_cnt;
    rxd = 1'b0;
    cyc(4);
    rxd = 1'b1;
    cyc(3 * DIV);
    chk("glitch_read_ready", 32'(read_ready), 32'd0);
    chk("glitch_data_out", 32'(data_out), 32'h3C);
    chk("glitch_frame_err", 32'(fe_cnt - fe0), 32'd0);

    // Receive table.
    for (int i = 0; i < 4; i++) begin
      if (rxv[i].pre_ack) begin
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
      end
      cyc(2 * DIV);
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(rxv[i].data, rxv[i].stop, -1, 1'b0);
      cyc(4);
      chk($sformatf("rx%0d_read_ready", i), 32'(read_ready), 32'(rxv[i].exp_rr));
      chk($sformatf("rx%0d_data_out", i), 32'(data_out), 32'(rxv[i].exp_dout));
      chk($sformatf("rx%0d_frame_err", i), 32'(fe_cnt - fe0), 32'(rxv[i].exp_fe));
      chk($sformatf("rx%0d_overrun", i), 32'(ov_cnt - ov0), 32'(rxv[i].exp_ov));
    end

    // Ack on the landing edge while a byte is still unread.
    cyc(2 * DIV);
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h5A, 1'b1, LAND_K - 1, 1'b0);
    cyc(4);
    chk("race_read_ready", 32'(read_ready), 32'd1);
    chk("race_data_out", 32'(data_out), 32'h5A);
    chk("race_no_overrun", 32'(ov_cnt - ov0), 32'd0);

    // Reset in the middle of a transmission takes effect immediately.
    data_in = 8'hF0;
    enable_write = 1'b1;
    cyc(1);
    enable_write = 1'b0;
    cyc(50);
    chk("midtx_line_low", 32'(txd), 32'd0);
    rst = 1'b1;
    #1;
    chk("midtx_rst_txd", 32'(txd), 32'd1);
    chk("midtx_rst_write_ready", 32'(write_ready), 32'd1);
    chk("midtx_rst_data_out", 32'(data_out), 32'h00);
    chk("midtx_rst_read_ready", 32'(read_ready), 32'd0);

    // Line held low through reset release must not start a frame.
    rxd = 1'b0;
    cyc(3);
    rst = 1'b0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    cyc(12 * DIV);
    rxd = 1'b1;
    cyc(12 * DIV);
    chk("lowrst_read_ready", 32'(read_ready), 32'd0);
    chk("lowrst_frame_err", 32'(fe_cnt - fe0), 32'd0);
    chk("lowrst_txd_idle", 32'(txd), 32'd1);

    // Reset part-way through a received frame discards it.
    rxd = 1'b0;
    cyc(3 * DIV);
    rst = 1'b1;
    rxd = 1'b1;
    cyc(2);
    rst = 1'b0;
    fe0 = fe_cnt;
    cyc(12 * DIV);
    chk("midrx_read_ready", 32'(read_ready), 32'd0);
    chk("midrx_data_out", 32'(data_out), 32'h00);
    chk("midrx_frame_err", 32'(fe_cnt - fe0), 32'd0);

    // Receiver still works after that reset.
    send_frame(8'h96, 1'b1, -1, 1'b0);
    cyc(4);
    chk("post_rst_rx_ready", 32'(read_ready), 32'd1);
    chk("post_rst_rx_data", 32'(data_out), 32'h96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
